// File: rtl/definitions_pkg.sv
// definitions_pkg: shared types and segment codes for the product BCD display
package definitions_pkg;
   localparam int BCD_DIGITS = 5;
   typedef logic [3:0] bcd_digit_t;
   typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} bcd_state_e;
   // gfedcba, active-low
   typedef enum logic [6:0] {
      SEG_0     = 7'h40,
      SEG_1     = 7'h79,
      SEG_2     = 7'h24,
      SEG_3     = 7'h30,
      SEG_4     = 7'h19,
      SEG_5     = 7'h12,
      SEG_6     = 7'h02,
      SEG_7     = 7'h78,
      SEG_8     = 7'h00,
      SEG_9     = 7'h10,
      SEG_MINUS = 7'h3F,
      SEG_BLANK = 7'h7F
   } segment_e;
   function automatic segment_e bcd_seg(bcd_digit_t d);
      case (d)
         4'd0:    return SEG_0;
         4'd1:    return SEG_1;
         4'd2:    return SEG_2;
         4'd3:    return SEG_3;
         4'd4:    return SEG_4;
         4'd5:    return SEG_5;
         4'd6:    return SEG_6;
         4'd7:    return SEG_7;
         4'd8:    return SEG_8;
         4'd9:    return SEG_9;
         default: return SEG_BLANK;
      endcase
   endfunction
endpackage

// File: rtl/bcd_to_segment.sv
// bcd_to_segment: combinational BCD digit to seven-segment code, blank above 9
module bcd_to_segment
   import definitions_pkg::*;
(
   input  bcd_digit_t bcd_i,
   output segment_e   seg_o
);
   assign seg_o = bcd_seg(bcd_i);
endmodule

// File: rtl/product_bcd_display.sv
// product_bcd_display: captures a signed product, double-dabbles its magnitude and drives registered segment digits
// LEADING_ZERO_BLANK_EN blanks zero digits above the most significant non-zero digit.
module product_bcd_display
   import definitions_pkg::*;
#(
   parameter int WIDTH  = 16,
   parameter int DIGITS = BCD_DIGITS
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             i_valid,
   input  logic [WIDTH-1:0] i_product,
   output logic             o_busy,
   output logic             o_done,
   output segment_e         o_ones,
   output segment_e         o_tens,
   output segment_e         o_hundreds,
   output segment_e         o_thousands,
   output segment_e         o_ten_thousands,
   output segment_e         o_sign
);
   localparam int BW = 4 * DIGITS;
   localparam int CW = $clog2(WIDTH);
   bcd_state_e state_q, state_d;
   logic [WIDTH-1:0] prod_q, prod_d, mag_q, mag_d;
   logic [BW-1:0] bcd_q, bcd_d, adj;
   logic [BW+WIDTH-1:0] dd;
   logic [CW-1:0] cnt_q, cnt_d;
   logic sign_q, sign_d, done_q, done_d, lz;
   segment_e seg_q [DIGITS];
   segment_e seg_d [DIGITS];
   segment_e disp [DIGITS];
   segment_e dec [DIGITS];
   segment_e sgn_q, sgn_d;

   for (genvar g = 0; g < DIGITS; g++) begin : g_dec
      bcd_to_segment u_dec (.bcd_i(bcd_q[4*g +: 4]), .seg_o(dec[g]));
   end

   always_comb begin
      for (int k = 0; k < DIGITS; k++)
         adj[4*k +: 4] = bcd_q[4*k +: 4] >= 4'd5 ? bcd_q[4*k +: 4] + 4'd3 : bcd_q[4*k +: 4];
      dd = {adj, mag_q} << 1;
   end

   // lz stays set while scanning down through leading zeros; ones digit always shows
   always_comb begin
`ifdef LEADING_ZERO_BLANK_EN
      lz = 1'b1;
`else
      lz = 1'b0;
`endif
      for (int k = DIGITS - 1; k >= 0; k--) begin
         lz = lz && bcd_q[4*k +: 4] == 4'd0 && k != 0;
         disp[k] = lz ? SEG_BLANK : dec[k];
      end
   end

   always_comb begin
      state_d = state_q;
      prod_d  = prod_q;
      mag_d   = mag_q;
      bcd_d   = bcd_q;
      cnt_d   = cnt_q;
      sign_d  = sign_q;
      done_d  = 1'b0;
      seg_d   = seg_q;
      sgn_d   = sgn_q;
      case (state_q)
         IDLE: begin
            if (i_valid) begin
               prod_d  = i_product;
               state_d = LOAD;
            end
         end
         LOAD: begin
            sign_d  = prod_q[WIDTH-1];
            mag_d   = prod_q[WIDTH-1] ? ~prod_q + 1'b1 : prod_q;
            bcd_d   = '0;
            cnt_d   = CW'(WIDTH - 1);
            state_d = SHIFT;
         end
         SHIFT: begin
            bcd_d   = dd[BW+WIDTH-1:WIDTH];
            mag_d   = dd[WIDTH-1:0];
            cnt_d   = cnt_q - 1'b1;
            state_d = cnt_q == '0 ? DONE : SHIFT;
         end
         DONE: begin
            seg_d   = disp;
            sgn_d   = (sign_q && bcd_q != '0) ? SEG_MINUS : SEG_BLANK;
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         prod_q  <= '0;
         mag_q   <= '0;
         bcd_q   <= '0;
         cnt_q   <= '0;
         sign_q  <= 1'b0;
         done_q  <= 1'b0;
         sgn_q   <= SEG_BLANK;
         for (int k = 0; k < DIGITS; k++) seg_q[k] <= SEG_BLANK;
      end else begin
         state_q <= state_d;
         prod_q  <= prod_d;
         mag_q   <= mag_d;
         bcd_q   <= bcd_d;
         cnt_q   <= cnt_d;
         sign_q  <= sign_d;
         done_q  <= done_d;
         sgn_q   <= sgn_d;
         seg_q   <= seg_d;
      end
   end

   assign o_busy          = state_q == LOAD || state_q == SHIFT;
   assign o_done          = done_q;
   assign o_ones          = seg_q[0];
   assign o_tens          = seg_q[1];
   assign o_hundreds      = seg_q[2];
   assign o_thousands     = seg_q[3];
   assign o_ten_thousands = seg_q[4];
   assign o_sign          = sgn_q;
endmodule

// File: tb/tb_product_bcd_display.sv
// tb_product_bcd_display: directed vectors checked against a decimal-arithmetic model every cycle
module tb_product_bcd_display;
`ifdef LEADING_ZERO_BLANK_EN
   localparam bit LZB = 1'b1;
   localparam logic [6:0] Z = 7'h7F;
`else
   localparam bit LZB = 1'b0;
   localparam logic [6:0] Z = 7'h40;
`endif
   localparam logic [6:0] B = 7'h7F;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic i_valid = 1'b0;
   logic [15:0] i_product = '0;
   logic o_busy, o_done;
   logic [6:0] o_ones, o_tens, o_hundreds, o_thousands, o_ten_thousands, o_sign;
   int checks = 0;
   int errors = 0;
   int t = 0;
   int mag, p10, lat;
   logic signed [15:0] m_p = '0;
   logic [6:0] m_seg [5] = '{default: 7'h7F};
   logic [6:0] m_sign = 7'h7F;
   logic m_done = 1'b0;
   logic m_busy = 1'b0;
   logic chk_en = 1'b0;

   always #5 clk = ~clk;

   product_bcd_display dut (
      .clk(clk), .rst(rst), .i_valid(i_valid), .i_product(i_product),
      .o_busy(o_busy), .o_done(o_done), .o_ones(o_ones), .o_tens(o_tens),
      .o_hundreds(o_hundreds), .o_thousands(o_thousands),
      .o_ten_thousands(o_ten_thousands), .o_sign(o_sign)
   );

   function automatic logic [6:0] seg7(int d);
      case (d)
         0: return 7'h40;
         1: return 7'h79;
         2: return 7'h24;
         3: return 7'h30;
         4: return 7'h19;
         5: return 7'h12;
         6: return 7'h02;
         7: return 7'h78;
         8: return 7'h00;
         9: return 7'h10;
         default: return 7'h7F;
      endcase
   endfunction

   // t counts edges since acceptance; results appear 18 edges after the capturing edge
   always @(posedge clk) begin
      if (rst) begin
         t = 0;
         m_done = 1'b0;
         m_sign = 7'h7F;
         foreach (m_seg[k]) m_seg[k] = 7'h7F;
      end else begin
         m_done = 1'b0;
         if (t == 0) begin
            if (i_valid) begin
               m_p = i_product;
               t = 1;
            end
         end else if (t == 18) begin
            mag = int'(m_p);
            if (mag < 0) mag = -mag;
            p10 = 1;
            for (int k = 0; k < 5; k++) begin
               m_seg[k] = (LZB && k > 0 && mag < p10) ? 7'h7F : seg7((mag / p10) % 10);
               p10 = p10 * 10;
            end
            m_sign = (m_p < 0 && mag != 0) ? 7'h3F : 7'h7F;
            m_done = 1'b1;
            t = 0;
         end else begin
            t++;
         end
      end
      m_busy = t >= 1 && t <= 17;
      chk_en = 1'b1;
   end

   always @(negedge clk) begin
      if (chk_en) begin
         checks++;
         if ({o_busy, o_done, o_sign, o_ten_thousands, o_thousands, o_hundreds, o_tens, o_ones} !==
             {m_busy, m_done, m_sign, m_seg[4], m_seg[3], m_seg[2], m_seg[1], m_seg[0]}) begin
            errors++;
            $display("FAIL cycle @%0t dut busy=%b done=%b segs=%h %h %h %h %h %h model busy=%b done=%b segs=%h %h %h %h %h %h",
                     $time, o_busy, o_done, o_sign, o_ten_thousands, o_thousands, o_hundreds, o_tens, o_ones,
                     m_busy, m_done, m_sign, m_seg[4], m_seg[3], m_seg[2], m_seg[1], m_seg[0]);
         end
      end
   end

   task automatic lit(input string nm, input logic [41:0] exp);
      logic [41:0] got;
      got = {o_sign, o_ten_thousands, o_thousands, o_hundreds, o_tens, o_ones};
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h", nm, got, exp);
      end
   endtask

   task automatic wait_done(input string nm, input logic [41:0] exp);
      int n = 0;
      while (!o_done && n < 40) begin
         @(negedge clk);
         n++;
      end
      lat = n;
      if (!o_done) begin
         errors++;
         $display("FAIL %s timeout waiting for o_done", nm);
      end
      lit(nm, exp);
   endtask

   task automatic conv(input logic [15:0] p, input string nm, input logic [41:0] exp);
      @(negedge clk);
      i_valid = 1'b1;
      i_product = p;
      @(negedge clk);
      i_valid = 1'b0;
      wait_done(nm, exp);
      checks++;
      if (lat != 18) begin
         errors++;
         $display("FAIL %s latency got %0d want 18", nm, lat);
      end
   endtask

   initial begin
      repeat (3) @(negedge clk);
      lit("reset_init", {B, B, B, B, B, B});
      rst = 1'b0;
      conv(16'hC080, "neg16256", {7'h3F, 7'h79, 7'h02, 7'h24, 7'h12, 7'h02});
      conv(16'h4000, "pos16384", {7'h7F, 7'h79, 7'h02, 7'h30, 7'h00, 7'h19});
      conv(16'h8000, "neg32768", {7'h3F, 7'h30, 7'h24, 7'h78, 7'h02, 7'h00});
      conv(16'h0000, "zero", {7'h7F, Z, Z, Z, Z, 7'h40});
      conv(16'd42, "p42", {7'h7F, Z, Z, Z, 7'h19, 7'h24});
      conv(16'd9999, "p9999", {7'h7F, Z, 7'h10, 7'h10, 7'h10, 7'h10});
      @(negedge clk);
      i_valid = 1'b1;
      i_product = 16'hFFFF;
      @(negedge clk);
      i_valid = 1'b0;
      repeat (4) @(negedge clk);
      i_valid = 1'b1;
      i_product = 16'd7;
      @(negedge clk);
      i_valid = 1'b0;
      wait_done("neg1_ignore7", {7'h3F, Z, Z, Z, Z, 7'h79});
      repeat (25) @(negedge clk);
      lit("neg1_held", {7'h3F, Z, Z, Z, Z, 7'h79});
      conv(16'd7, "p7", {7'h7F, Z, Z, Z, Z, 7'h78});
      @(negedge clk);
      i_valid = 1'b1;
      i_product = 16'd12345;
      @(negedge clk);
      i_valid = 1'b0;
      repeat (7) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if (o_busy !== 1'b0 || o_done !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid busy=%b done=%b want 0 0", o_busy, o_done);
      end
      lit("reset_mid", {B, B, B, B, B, B});
      repeat (25) @(negedge clk);
      conv(16'd255, "p255", {7'h7F, Z, Z, 7'h24, 7'h12, 7'h12});
      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/product_bcd_display.md
Name: product_bcd_display

Overview:
Downstream consumer of the Booth multiplier's signed 16-bit product. It captures the product when the multiplier signals ready. It converts the magnitude to BCD with a sequential shift-add-3 (double-dabble) engine. It drives registered seven-segment codes for five digits plus a sign digit, replacing the multiplier's internal display path on the board.

Parameters:
WIDTH, 16, product width in bits; the shift counter runs WIDTH cycles
DIGITS, 5, BCD digits produced; 5 covers |−32768| and the full 8x8 signed range (max 16384)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
i_valid  input  1  product valid; connect to multiplier o_rdy; sampled only in IDLE
i_product  input  WIDTH  signed two's-complement product
o_busy  output  1  high in LOAD and SHIFT
o_done  output  1  one-cycle pulse when display outputs update
o_ones, o_tens, o_hundreds, o_thousands, o_ten_thousands  output  7 each (segment_e)  digit segment codes
o_sign  output  7 (segment_e)  SEG_MINUS when the product is negative, else SEG_BLANK

Behaviour:
- Reset: the only reset is synchronous and active-high on rst. The clock port is clk and the reset port is rst.
- Reset values: state IDLE, o_busy=0, o_done=0, all digit outputs and o_sign = SEG_BLANK, internal shift/BCD registers = 0.
- FSM states: IDLE, LOAD, SHIFT, DONE.
- IDLE:
  - i_valid=1 → LOAD; i_product is captured into a holding register on that edge.
  - i_valid=0 → stay in IDLE.
- LOAD (1 cycle):
  - sign_r = product[WIDTH-1].
  - mag_r = sign ? (~product + 1) : product, treated as unsigned WIDTH bits, so 0x8000 → 32768 is exact.
  - BCD register cleared; bit counter = WIDTH-1.
  - Next state SHIFT.
- SHIFT (exactly WIDTH cycles):
  - Each cycle, every BCD nibble >= 5 gets +3 first.
  - Then {bcd, mag} is shifted left by 1.
  - The counter decrements; leaving on count 0 → DONE.
- DONE (1 cycle):
  - The BCD nibbles are decoded and registered onto the digit outputs.
  - o_sign = (sign_r && mag != 0) ? SEG_MINUS : SEG_BLANK.
  - o_done = 1; next state IDLE.
- Latency: i_valid sampled at edge N → o_done high and outputs updated after edge N+WIDTH+2, i.e. 18 cycles for WIDTH=16.
- Outputs hold their last value until the next DONE. No glitching or partial digits are visible during SHIFT.
- i_valid while not in IDLE: ignored, with no queuing. i_valid held high continuously: a new capture happens in the first IDLE cycle after DONE.
- rst asserted mid-conversion: returns to IDLE next edge, and all outputs go to their reset values (SEG_BLANK), not the last result.
- BCD nibbles never exceed 9 after conversion. A nibble value >9 is decoded as SEG_BLANK (defensive).
- Segment encoding: segment_e from definitions_pkg, gfedcba, active-low.

Optional Feature:
Macro LEADING_ZERO_BLANK_EN.
- Defined: in DONE, zero digits above the most significant non-zero digit are driven SEG_BLANK. o_ones always shows a digit, so 0 displays "0". The sign is still driven on o_sign only (fixed position).
- Undefined: all five digits always show, including leading zeros ("00042").

Decomposition:
- definitions_pkg additions:
  - segment_e members SEG_0..SEG_9, SEG_BLANK, SEG_MINUS.
  - bcd_state_e {IDLE, LOAD, SHIFT, DONE}.
  - bcd_digit_t (logic [3:0]).
  - localparam BCD_DIGITS = 5.
- Sub-module bcd_to_segment: combinational bcd_digit_t → segment_e, instantiated DIGITS times.
- The double-dabble engine and the FSM stay in product_bcd_display.

Test Plan:
- i_product = −16256 (0xC080, i.e. −128*127), 1-cycle i_valid → o_done after 18 cycles; o_sign=SEG_MINUS; digits 1,6,2,5,6 (ten_thousands..ones).
- i_product = 16384 (0x4000) → o_sign=SEG_BLANK; digits 1,6,3,8,4.
- i_product = 0x8000 → SEG_MINUS; digits 3,2,7,6,8. i_product = 0 → o_sign=SEG_BLANK.
  - With LEADING_ZERO_BLANK_EN, 0 shows o_ones=SEG_0 and the others SEG_BLANK.
  - Without it, 0 shows all SEG_0.
- i_product = 42 with LEADING_ZERO_BLANK_EN → ones=SEG_2, tens=SEG_4, upper three SEG_BLANK. Without the macro → 0,0,0,4,2.
- Second i_valid (product 7) pulsed 5 cycles after the first (product −1) → ignored. Only one o_done occurs, and it shows −1. A fresh i_valid after done converts 7 normally.
- rst pulsed 8 cycles into a conversion → next cycle o_busy=0, all outputs SEG_BLANK, no o_done. A following conversion of 255 gives 0,0,2,5,5.
